muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits in the EX stage next to the ALU and is parametrised in operand width. It holds the pipeline through a stall output while it computes, then returns one result with a single-cycle done pulse. Pipeline flush aborts an operation in flight.

Parameters:
XLEN, 32, operand/result width in bits; must be ≥4 and even.
CNT_W, $clog2(XLEN), iteration counter width.

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rst_i  input  1  asynchronous reset, active-high.
valid_i  input  1  operation request; sampled only in IDLE.
funct3_i  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
data1_i  input  XLEN  rs1 operand (multiplicand / dividend).
data2_i  input  XLEN  rs2 operand (multiplier / divisor).
flush_i  input  1  abort the current operation.
stall_o  output  1  combinational hold request to the pipeline.
done_o  output  1  registered single-cycle result-valid pulse.
result_o  output  XLEN  registered result; held until the next completion.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, counter=0, done_o=0, result_o=0, all internal accumulators=0. stall_o then evaluates to valid_i.
- States: IDLE, CALC, DONE.
- IDLE: on an edge with valid_i=1 and flush_i=0, latch funct3 and the operands. Normal path goes to CALC with counter=0.
- Fast path goes directly to DONE with the result registered. It applies to:
  - divisor==0: DIV/DIVU quotient = all ones; REM/REMU = dividend.
  - signed overflow (DIV/REM, dividend = 1 followed by XLEN-1 zeros, divisor = all ones): quotient = dividend; remainder = 0.
- CALC: one iteration per edge.
  - Multiply: shift-add over the 2*XLEN-bit product.
  - Divide: restoring, one quotient bit per cycle.
  - Signed ops work on magnitudes. The result sign is fixed up at completion:
    - product is negative if the operand signs differ; for MULHSU only rs1 is signed.
    - quotient is negative if the operand signs differ.
    - remainder takes the sign of the dividend.
  - At the edge where counter==XLEN-1, register result_o and go to DONE.
- Result selection:
  - MUL returns product[XLEN-1:0].
  - MULH, MULHSU and MULHU return product[2*XLEN-1:XLEN].
- DONE: done_o=1 for exactly one cycle, then IDLE. A valid_i seen during DONE is ignored; the pipeline re-presents it in IDLE only if it is a new instruction.
- Latency, counting cycle 1 as the cycle after the acceptance edge:
  - Normal path: CALC occupies cycles 1..XLEN; done_o=1 in cycle XLEN+1.
  - Fast path: done_o=1 in cycle 1.
- stall_o = (state==IDLE & valid_i & ~flush_i) | (state==CALC). It is 0 in DONE, so the pipeline advances and captures result_o in that cycle.
- flush_i=1 on an edge:
  - In CALC: return to IDLE; result_o is not updated and done_o stays 0.
  - In DONE: done_o still ends after its one cycle, and result_o keeps its value.
  - In IDLE: blocks acceptance.
- valid_i or operand changes during CALC are ignored, because latched copies are used.
- Reset mid-CALC: immediate return to IDLE and outputs cleared; no done pulse.
- Width rules: the product accumulator is 2*XLEN bits. The divide remainder register is XLEN+1 bits to hold the subtract borrow. The counter does not wrap; it is compared against XLEN-1.
- result_o changes only on a DONE entry edge or on reset.

Test Plan (XLEN=32):
- MUL 7 × 0xFFFFFFFD (−3) -> stall_o high cycles 0..32; done_o in cycle 33 with result_o=0xFFFFFFEB. Also MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2. Each has done_o in cycle 33.
- DIVU 5/0 -> 0xFFFFFFFF with done_o in cycle 1. REM 5/0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, and REM of the same operands -> 0, both with 1-cycle latency.
- Start DIV 100/7, assert flush_i in cycle 10 -> state IDLE, no done_o, result_o keeps its prior value. A new MUL 3×4 is then accepted and gives 12.
- Assert rst_i asynchronously mid-CALC (cycle 15) -> done_o=0, result_o=0, stall_o=valid_i immediately. Raise valid_i during CALC with different operands -> ignored; the original result is returned.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Pipeline-side bus of the iterative multiply/divide unit.
//   valid_i  : operation request
//   funct3_i : RV32M op select
//   data1_i  : rs1 operand (multiplicand / dividend)
//   data2_i  : rs2 operand (multiplier / divisor)
//   flush_i  : abort the operation in flight
//   stall_o  : combinational hold request to the pipeline
//   done_o   : registered single-cycle result-valid pulse
//   result_o : registered result, held until the next completion
// master = pipeline (EX stage), slave = muldiv_unit.
interface muldiv_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            valid_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] data1_i;
    logic [XLEN-1:0] data2_i;
    logic            flush_i;
    logic            stall_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output valid_i, funct3_i, data1_i, data2_i, flush_i,
        input  stall_o, done_o, result_o
    );

    modport slave (
        input  valid_i, funct3_i, data1_i, data2_i, flush_i,
        output stall_o, done_o, result_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
// Shift-add multiply and restoring divide on operand magnitudes, one step per cycle,
// with the sign applied when the result is registered. Divide-by-zero and signed
// overflow take a one-cycle fast path.
//   clk_i : clock, rising edge
//   rst_i : asynchronous reset, active-high
//   bus   : muldiv_unit_if slave port (request, operands, flush, stall, done, result)
module muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    muldiv_unit_if.slave bus
);
    localparam int unsigned      PW       = 2 * XLEN;
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [XLEN-1:0]  a_q, a_d;        // rs1 magnitude (multiplicand)
    logic [XLEN-1:0]  b_q, b_d;        // rs2 magnitude (divisor)
    logic             neg_q, neg_d;    // result must be negated at completion
    logic [PW-1:0]    prod_q, prod_d;  // {partial sum, remaining multiplier bits}
    logic [XLEN:0]    rem_q, rem_d;    // partial remainder with borrow bit
    logic [XLEN-1:0]  quo_q, quo_d;    // dividend bits shift out, quotient bits shift in
    logic             done_q, done_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic             stall_c;

    // Request decode: operand signedness, magnitudes and fast-path cases
    logic            a_signed, b_signed, neg_a, neg_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf, fast_path;
    logic [XLEN-1:0] fast_result;

    always_comb begin
        a_signed    = (bus.funct3_i == 3'b001) || (bus.funct3_i == 3'b010) ||
                      (bus.funct3_i == 3'b100) || (bus.funct3_i == 3'b110);
        b_signed    = (bus.funct3_i == 3'b001) || (bus.funct3_i == 3'b100) ||
                      (bus.funct3_i == 3'b110);
        neg_a       = a_signed && bus.data1_i[XLEN-1];
        neg_b       = b_signed && bus.data2_i[XLEN-1];
        mag_a       = neg_a ? -bus.data1_i : bus.data1_i;
        mag_b       = neg_b ? -bus.data2_i : bus.data2_i;
        div_zero    = bus.funct3_i[2] && (bus.data2_i == '0);
        div_ovf     = bus.funct3_i[2] && !bus.funct3_i[0] &&
                      (bus.data1_i == MIN_NEG) && (bus.data2_i == '1);
        fast_path   = div_zero || div_ovf;
        fast_result = '0;
        if (div_zero) begin
            fast_result = bus.funct3_i[1] ? bus.data1_i : '1;
        end else if (div_ovf) begin
            fast_result = bus.funct3_i[1] ? '0 : bus.data1_i;
        end
    end

    // One multiply step and one divide step, plus the sign-fixed final result
    logic [XLEN-1:0] addend;
    logic [XLEN:0]   mul_sum;
    logic [PW-1:0]   prod_step, prod_fix;
    logic [XLEN:0]   rem_shift, rem_diff, rem_step;
    logic [XLEN-1:0] quo_step, quo_fix, rem_fix;
    logic [XLEN-1:0] calc_result;

    always_comb begin
        addend    = prod_q[0] ? a_q : '0;
        mul_sum   = {1'b0, prod_q[PW-1:XLEN]} + {1'b0, addend};
        prod_step = {mul_sum, prod_q[XLEN-1:1]};

        // The stored remainder is always below the divisor, so its top bit is zero
        // and shifting it out loses nothing.
        rem_shift = (XLEN+1)'({rem_q, quo_q[XLEN-1]});
        rem_diff  = rem_shift - {1'b0, b_q};
        if (rem_diff[XLEN]) begin
            rem_step = rem_shift;
            quo_step = {quo_q[XLEN-2:0], 1'b0};
        end else begin
            rem_step = rem_diff;
            quo_step = {quo_q[XLEN-2:0], 1'b1};
        end

        prod_fix = neg_q ? -prod_step : prod_step;
        quo_fix  = neg_q ? -quo_step : quo_step;
        rem_fix  = neg_q ? -rem_step[XLEN-1:0] : rem_step[XLEN-1:0];

        case (op_q)
            3'b000:                 calc_result = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: calc_result = prod_fix[PW-1:XLEN];
            3'b100, 3'b101:         calc_result = quo_fix;
            default:                calc_result = rem_fix;
        endcase
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        neg_d    = neg_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        done_d   = 1'b0;
        result_d = result_q;
        stall_c  = 1'b0;

        case (state_q)
            IDLE: begin
                stall_c = bus.valid_i && !bus.flush_i;
                if (stall_c) begin
                    op_d   = bus.funct3_i;
                    a_d    = mag_a;
                    b_d    = mag_b;
                    // REM takes the dividend's sign; products and quotients the XOR
                    neg_d  = (bus.funct3_i[2] && bus.funct3_i[1]) ? neg_a : (neg_a ^ neg_b);
                    cnt_d  = '0;
                    prod_d = {{XLEN{1'b0}}, mag_b};
                    rem_d  = '0;
                    quo_d  = mag_a;
                    if (fast_path) begin
                        result_d = fast_result;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                stall_c = 1'b1;
                if (bus.flush_i) begin
                    state_d = IDLE;
                end else begin
                    prod_d = prod_step;
                    rem_d  = rem_step;
                    quo_d  = quo_step;
                    if (cnt_q == CNT_LAST) begin
                        result_d = calc_result;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            prod_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign bus.stall_o  = stall_c;
    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed RV32M cases, fast paths,
// flush, asynchronous reset mid-operation, ignored requests during CALC, and
// random operations against a 64-bit arithmetic reference model.
module tb_muldiv_unit;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [31:0] last_res;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Reference: RV32M semantics in plain 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin if (b == 32'd0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 32'd0) return 32'hFFFF_FFFF; up = ua / ub; return up[31:0]; end
            3'd6: begin if (b == 32'd0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 32'd0) return a; up = ua % ub; return up[31:0]; end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (op[2] && b == 32'd0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one op, count cycles to done_o, check latency, result, stall and pulse width.
    // With noise set, valid_i and operands toggle during CALC and must be ignored.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit noise, input string tag);
        logic [31:0] exp_res;
        int          exp_lat;
        int          cyc;
        bit          got;
        bit          stall_ok;
        exp_res = ref_model(op, a, b);
        exp_lat = ref_lat(op, a, b);
        @(negedge clk);
        bus.valid_i  = 1'b1;
        bus.funct3_i = op;
        bus.data1_i  = a;
        bus.data2_i  = b;
        #1;
        stall_ok = (bus.stall_o === 1'b1);
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.data1_i = $urandom;
        bus.data2_i = $urandom;
        cyc = 1;
        got = 1'b0;
        while (!got && cyc <= 40) begin
            if (bus.done_o === 1'b1) begin
                got = 1'b1;
            end else begin
                if (bus.stall_o !== 1'b1) stall_ok = 1'b0;
                if (noise) begin
                    bus.valid_i  = (cyc >= 2 && cyc <= 20);
                    bus.funct3_i = 3'($urandom);
                    bus.data1_i  = $urandom;
                    bus.data2_i  = $urandom;
                end
                @(negedge clk);
                cyc++;
            end
        end
        bus.valid_i = 1'b0;
        #1;
        check({tag, " done_seen"}, 32'(got), 32'd1);
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " result"}, bus.result_o, exp_res);
        check({tag, " stall"}, 32'(stall_ok && bus.stall_o === 1'b0), 32'd1);
        @(negedge clk);
        check({tag, " pulse_end"}, 32'(bus.done_o), 32'd0);
        check({tag, " result_hold"}, bus.result_o, exp_res);
        last_res = exp_res;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 6))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'd0;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit          saw_done;
        bit          stall_bad;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        total    = 0;
        bad      = 0;
        last_res = 32'd0;
        rst          = 1'b1;
        bus.valid_i  = 1'b0;
        bus.funct3_i = 3'd0;
        bus.data1_i  = 32'd0;
        bus.data2_i  = 32'd0;
        bus.flush_i  = 1'b0;

        // Reset state
        #2;
        check("rst done", 32'(bus.done_o), 32'd0);
        check("rst result", bus.result_o, 32'd0);
        check("rst stall_idle", 32'(bus.stall_o), 32'd0);
        bus.valid_i = 1'b1;
        #1;
        check("rst stall_valid", 32'(bus.stall_o), 32'd1);
        bus.valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, "MUL 7x-3");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "MULHU max");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, "MULH min");
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, "MULHSU -1x2");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, "DIV -7/2");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, "REM -7/2");
        run_op(3'd5, 32'd100, 32'd7, 1'b0, "DIVU 100/7");
        run_op(3'd7, 32'd100, 32'd7, 1'b0, "REMU 100/7");
        run_op(3'd5, 32'd5, 32'd0, 1'b0, "DIVU 5/0");
        run_op(3'd6, 32'd5, 32'd0, 1'b0, "REM 5/0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "DIV ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "REM ovf");

        // Flush in CALC cycle 10: no done, result untouched
        @(negedge clk);
        bus.valid_i  = 1'b1;
        bus.funct3_i = 3'd4;
        bus.data1_i  = 32'd100;
        bus.data2_i  = 32'd7;
        @(negedge clk);
        bus.valid_i = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        saw_done  = 1'b0;
        stall_bad = 1'b0;
        repeat (40) begin
            if (bus.done_o === 1'b1) saw_done = 1'b1;
            if (bus.stall_o !== 1'b0) stall_bad = 1'b1;
            @(negedge clk);
        end
        check("flush no_done", 32'(saw_done), 32'd0);
        check("flush idle_stall", 32'(stall_bad), 32'd0);
        check("flush result_kept", bus.result_o, last_res);
        run_op(3'd0, 32'd3, 32'd4, 1'b0, "MUL 3x4 after flush");

        // Flush during DONE: pulse still one cycle, result kept
        @(negedge clk);
        bus.valid_i  = 1'b1;
        bus.funct3_i = 3'd5;
        bus.data1_i  = 32'd9;
        bus.data2_i  = 32'd0;
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b1;
        #1;
        check("done_flush pulse", 32'(bus.done_o), 32'd1);
        check("done_flush result", bus.result_o, 32'hFFFF_FFFF);
        @(negedge clk);
        bus.flush_i = 1'b0;
        #1;
        check("done_flush pulse_end", 32'(bus.done_o), 32'd0);
        check("done_flush hold", bus.result_o, 32'hFFFF_FFFF);

        // Asynchronous reset in CALC cycle 15
        @(negedge clk);
        bus.valid_i  = 1'b1;
        bus.funct3_i = 3'd0;
        bus.data1_i  = 32'h1234;
        bus.data2_i  = 32'h55;
        @(negedge clk);
        bus.valid_i = 1'b0;
        repeat (14) @(negedge clk);
        bus.valid_i = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst done", 32'(bus.done_o), 32'd0);
        check("arst result", bus.result_o, 32'd0);
        check("arst stall_valid1", 32'(bus.stall_o), 32'd1);
        bus.valid_i = 1'b0;
        #1;
        check("arst stall_valid0", 32'(bus.stall_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            if (bus.done_o === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        check("arst no_done", 32'(saw_done), 32'd0);
        last_res = 32'd0;

        // Requests and operand changes during CALC are ignored
        run_op(3'd5, 32'd1000, 32'd3, 1'b1, "DIVU noise");
        run_op(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, "MULH noise");

        // Random operations
        for (int i = 0; i < 48; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick_val();
            rb  = pick_val();
            run_op(rop, ra, rb, 1'b0, $sformatf("rand%0d op%0d", i, rop));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
